// File: rtl/decoder_seq.sv
// decoder_seq: registered IN_W-to-2**IN_W decoder with onehot, accumulate,
// sweep and clear operations behind valid/ready handshakes.
// Optional accumulator register: define DECODER_SEQ_ACCUM_EN.
module decoder_seq #(
  parameter int IN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      in,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2**IN_W-1:0]   out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int OUT_W = 2**IN_W;

  localparam logic [1:0] M_ONEHOT = 2'b00;
  localparam logic [1:0] M_ACCUM  = 2'b01;
  localparam logic [1:0] M_SWEEP  = 2'b10;
  localparam logic [1:0] M_CLEAR  = 2'b11;

  localparam logic [IN_W-1:0] LAST_IDX = '1;
  localparam logic [OUT_W-1:0] ONE =
    {{(OUT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [OUT_W-1:0] r_out;
  logic [OUT_W-1:0] w_out_nxt;
  logic             r_ov;
  logic             w_ov_nxt;
  logic [IN_W-1:0]  r_idx;
  logic [IN_W-1:0]  w_idx_nxt;
`ifdef DECODER_SEQ_ACCUM_EN
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] w_acc_nxt;
`endif

  logic             w_take;
  logic             w_accept;
  logic [OUT_W-1:0] w_dec_in;
  logic [OUT_W-1:0] w_dec_idx;

  assign w_take    = r_ov & out_ready;
  assign in_ready  = (r_state == S_IDLE) &
                     (~r_ov | out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_dec_in  = ONE << in;
  assign w_dec_idx = ONE << r_idx;

  assign out       = r_out;
  assign out_valid = r_ov;
  assign busy      = (r_state == S_SWEEP);

  // State register; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output beat, sweep index and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_ov  <= 1'b0;
      r_idx <= '0;
`ifdef DECODER_SEQ_ACCUM_EN
      r_acc <= '0;
`endif
    end else begin
      r_out <= w_out_nxt;
      r_ov  <= w_ov_nxt;
      r_idx <= w_idx_nxt;
`ifdef DECODER_SEQ_ACCUM_EN
      r_acc <= w_acc_nxt;
`endif
    end
  end

  // Next state and next beat: accept in IDLE, step on each take in SWEEP.
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_ov_nxt    = r_ov & ~w_take;
    w_idx_nxt   = r_idx;
`ifdef DECODER_SEQ_ACCUM_EN
    w_acc_nxt   = r_acc;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_ov_nxt = 1'b1;
          unique case (mode)
            M_ONEHOT: begin
              w_out_nxt = w_dec_in;
            end
            M_ACCUM: begin
`ifdef DECODER_SEQ_ACCUM_EN
              w_acc_nxt = r_acc | w_dec_in;
              w_out_nxt = r_acc | w_dec_in;
`else
              w_out_nxt = w_dec_in;
`endif
            end
            M_SWEEP: begin
              w_out_nxt = w_dec_in;
              if (in != LAST_IDX) begin
                w_idx_nxt   = in + 1'b1;
                w_state_nxt = S_SWEEP;
              end
            end
            M_CLEAR: begin
              w_out_nxt = '0;
`ifdef DECODER_SEQ_ACCUM_EN
              w_acc_nxt = '0;
`endif
            end
            default: begin
              w_out_nxt = r_out;
            end
          endcase
        end
      end
      S_SWEEP: begin
        if (w_take) begin
          w_out_nxt = w_dec_idx;
          w_ov_nxt  = 1'b1;
          w_idx_nxt = r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = r_idx;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed vectors against a beat-queue model of
// decoder_seq, plus literal expectations at the key cycles.
module tb_decoder_seq;

  localparam int IN_W  = 4;
  localparam int OUT_W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in_s = '0;
  logic [1:0]  mode = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic [15:0] out_s;
  logic        out_valid;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  decoder_seq #(.IN_W(IN_W)) dut (
    .clk(clk),
    .rst(rst),
    .in(in_s),
    .mode(mode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out(out_s),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy)
  );

  // Model: current beat, its valid flag, beats still owed by a sweep.
  logic [15:0] m_out = '0;
  logic        m_ov  = 1'b0;
  logic [15:0] m_acc = '0;
  logic [15:0] m_q[$];

  function automatic logic [15:0] bit_of(int k);
    logic [15:0] b;
    b = '0;
    b[k] = 1'b1;
    return b;
  endfunction

  task automatic check(string nm, logic [15:0] got,
                       logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h at %0t",
               nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    logic tk;
    logic ac;
    if (rst) begin
      m_q.delete();
      m_out = '0;
      m_ov  = 1'b0;
      m_acc = '0;
    end else begin
      tk = m_ov && out_ready;
      ac = in_valid && (m_q.size() == 0) &&
           (!m_ov || out_ready);
      if (tk) begin
        if (m_q.size() > 0) m_out = m_q.pop_front();
        else m_ov = 1'b0;
      end
      if (ac) begin
        m_ov = 1'b1;
        case (mode)
          2'd0: m_out = bit_of(int'(in_s));
          2'd1: begin
`ifdef DECODER_SEQ_ACCUM_EN
            m_acc = m_acc | bit_of(int'(in_s));
            m_out = m_acc;
`else
            m_out = bit_of(int'(in_s));
`endif
          end
          2'd2: begin
            m_out = bit_of(int'(in_s));
            for (int k = int'(in_s) + 1; k < OUT_W; k++)
              m_q.push_back(bit_of(k));
          end
          default: begin
            m_out = '0;
            m_acc = '0;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out", out_s, m_out);
      check("out_valid", 16'(out_valid), 16'(m_ov));
      check("busy", 16'(busy), 16'(m_q.size() != 0));
      check("in_ready", 16'(in_ready),
            16'((m_q.size() == 0) && (!m_ov || out_ready)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [1:0] m, logic [3:0] i);
    in_valid = 1'b1;
    mode     = m;
    in_s     = i;
    cyc();
    in_valid = 1'b0;
  endtask

  logic [15:0] pat;

  initial begin
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_out", out_s, 16'h0000);
    check("rst_ov", 16'(out_valid), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_in_ready", 16'(in_ready), 16'h1);

    send(2'd0, 4'hB);
    check("onehot_B", out_s, 16'h0800);
    check("onehot_B_ov", 16'(out_valid), 16'h1);
    in_valid = 1'b1;
    in_s = 4'd0; cyc(); check("b2b_0", out_s, 16'h0001);
    in_s = 4'd1; cyc(); check("b2b_1", out_s, 16'h0002);
    in_s = 4'd2; cyc(); check("b2b_2", out_s, 16'h0004);
    in_valid = 1'b0;
    cyc();
    check("drain_ov", 16'(out_valid), 16'h0);
    check("drain_out", out_s, 16'h0004);

    send(2'd1, 4'd2);
    check("accum_2", out_s, 16'h0004);
    send(2'd1, 4'd5);
`ifdef DECODER_SEQ_ACCUM_EN
    check("accum_5", out_s, 16'h0024);
`else
    check("accum_5", out_s, 16'h0020);
`endif
    send(2'd3, 4'd0);
    check("clear", out_s, 16'h0000);
    check("clear_ov", 16'(out_valid), 16'h1);
    send(2'd1, 4'd0);
    check("accum_0", out_s, 16'h0001);

    send(2'd2, 4'd13);
    check("sw13_a", out_s, 16'h2000);
    check("sw13_busy_a", 16'(busy), 16'h1);
    check("sw13_rdy_a", 16'(in_ready), 16'h0);
    in_valid = 1'b1; mode = 2'd0; in_s = 4'd9;
    cyc();
    check("sw13_b", out_s, 16'h4000);
    check("sw13_busy_b", 16'(busy), 16'h1);
    cyc();
    check("sw13_c", out_s, 16'h8000);
    check("sw13_busy_c", 16'(busy), 16'h0);
    check("sw13_rdy_c", 16'(in_ready), 16'h1);
    cyc();
    check("after_sweep", out_s, 16'h0200);
    in_valid = 1'b0;
    cyc();

    send(2'd2, 4'd15);
    check("sw15", out_s, 16'h8000);
    check("sw15_busy", 16'(busy), 16'h0);
    cyc();

    out_ready = 1'b0;
    send(2'd0, 4'd3);
    check("hold_out", out_s, 16'h0008);
    check("hold_rdy", 16'(in_ready), 16'h0);
    in_valid = 1'b1; in_s = 4'd7;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("hold_out_n", out_s, 16'h0008);
      check("hold_ov_n", 16'(out_valid), 16'h1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("release_rdy", 16'(in_ready), 16'h1);
    cyc();
    check("release_ov", 16'(out_valid), 16'h0);

    send(2'd2, 4'd0);
    cyc();
    cyc();
    check("sw0_3rd", out_s, 16'h0004);
    rst = 1'b1;
    in_valid = 1'b1; mode = 2'd0; in_s = 4'd5;
    cyc();
    check("abort_out", out_s, 16'h0000);
    check("abort_ov", 16'(out_valid), 16'h0);
    check("abort_busy", 16'(busy), 16'h0);
    check("abort_rdy", 16'(in_ready), 16'h1);
    rst = 1'b0;
    in_valid = 1'b0;
    send(2'd1, 4'd3);
    check("acc_after_rst", out_s, 16'h0008);

    pat = 16'b1011_0011_1010_0101;
    out_ready = pat[0];
    send(2'd2, 4'd10);
    for (int i = 1; i < 16; i++) begin
      out_ready = pat[i];
      cyc();
    end
    out_ready = 1'b1;
    repeat (8) cyc();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 SHALL have parameter IN_W, default 4: select width; OUT_W = 2**IN_W is derived locally and not overridable.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in, input, IN_W, the select index.
REQ-005 SHALL have port mode, input, 2, operation: 00 ONEHOT, 01 ACCUM, 10 SWEEP, 11 CLEAR.
REQ-006 SHALL have port in_valid, input, 1, request present.
REQ-007 SHALL have port in_ready, output, 1, request accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port out, output, OUT_W, registered decoded word.
REQ-009 SHALL have port out_valid, output, 1, out holds an untaken beat.
REQ-010 SHALL have port out_ready, input, 1, beat taken when out_valid and out_ready are both high.
REQ-011 SHALL have port busy, output, 1, high while in SWEEP state.

Function
REQ-012 SHALL implement two states: IDLE and SWEEP.
REQ-013 SHALL drive in_ready = (state==IDLE) and (!out_valid or out_ready), combinationally.
REQ-014 SHALL register each produced beat into out and set out_valid on the clock edge after acceptance (latency 1 cycle).
REQ-015 ONEHOT: out = 1 << in.
REQ-016 ACCUM: acc <= acc | (1 << in); out = acc | (1 << in), i.e. the updated mask.
REQ-017 CLEAR: acc <= 0; out = 0, still emitted as a valid beat.
REQ-018 SWEEP accept: emit 1 << in, load sweep_idx = in + 1, enter SWEEP; if in == OUT_W-1, emit that single beat and stay IDLE.
REQ-019 In SWEEP, on each out_valid and out_ready: emit 1 << sweep_idx and increment sweep_idx; after emitting index OUT_W-1, return to IDLE.
REQ-020 SWEEP SHALL never wrap past OUT_W-1 and SHALL NOT modify acc.
REQ-021 When out_valid is high and out_ready is low, out and out_valid SHALL hold stable.
REQ-022 When a beat is taken with no new beat produced, out_valid SHALL clear next cycle; out retains its last value.
REQ-023 Take and produce in the same cycle SHALL sustain one beat per cycle with no bubble.
REQ-024 mode and in SHALL be sampled only at acceptance; changes during SWEEP SHALL be ignored.
REQ-025 busy SHALL equal (state==SWEEP).

Reset
REQ-026 On rst high at a clock edge: state IDLE, out = 0, out_valid = 0, acc = 0, sweep_idx = 0, busy = 0.
REQ-027 Reset mid-SWEEP SHALL abort the sweep immediately with no further beats.
REQ-028 rst SHALL override any simultaneous accept or take in that cycle.

Configuration
REQ-029 Macro DECODER_SEQ_ACCUM_EN defined: acc register present; ACCUM and CLEAR behave per REQ-016 and REQ-017.
REQ-030 DECODER_SEQ_ACCUM_EN undefined: no acc register; ACCUM behaves as ONEHOT; CLEAR emits out = 0 with out_valid.

Verification (IN_W=4, DECODER_SEQ_ACCUM_EN defined unless noted)
REQ-031 ONEHOT in=4'hB, out_ready=1 -> next cycle out=16'h0800, out_valid=1; back-to-back in=0,1,2 -> 16'h0001,16'h0002,16'h0004 on consecutive cycles.
REQ-032 ACCUM in=2, then 5, then CLEAR, then ACCUM 0 -> out=16'h0004, 16'h0024, 16'h0000, 16'h0001.
REQ-033 SWEEP in=13, out_ready=1 -> out=16'h2000,16'h4000,16'h8000 over 3 cycles; busy high 2 cycles; in_ready low until last beat taken.
REQ-034 ONEHOT in=3 with out_ready=0 for 4 cycles -> out=16'h0008 held, in_ready=0; out_ready=1 -> beat taken, in_ready=1 same cycle.
REQ-035 SWEEP in=0, assert rst after 3 beats -> next cycle out=0, out_valid=0, busy=0, in_ready=1.
REQ-036 Macro undefined: ACCUM in=2 then 5 -> out=16'h0004 then 16'h0020.
